// File: rtl/cpu_io_pkg.sv
// Shared types for the CPU I/O bus unit: FSM states, the latched request
// record and the timeout counter sizing helper.
package cpu_io_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_IN  = 2'd1,
      WAIT_OUT = 2'd2
   } io_state_e;

   // The request record is sized for the widest supported configuration;
   // the top keeps only the low PORT_W / DATA_W bits, so PORT_W must not
   // exceed REQ_PORT_MAX_W and DATA_W must not exceed REQ_DATA_MAX_W.
   localparam int REQ_PORT_MAX_W = 8;
   localparam int REQ_DATA_MAX_W = 32;

   typedef struct packed {
      logic                      write;
      logic [REQ_PORT_MAX_W-1:0] port;
      logic [REQ_DATA_MAX_W-1:0] data;
   } io_req_t;

   // Counter must hold values up to the timeout limit; never narrower than 1 bit.
   function automatic int io_cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cpu_io_unit_io_slot.sv
// Single-entry valid/ready holding register. A load wins over a drain or
// clear in the same cycle; the data word is only ever cleared by reset.
module io_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              drain,
   input  logic              clear,
   output logic              full,
   output logic [DATA_W-1:0] data
);

   // Occupancy flag and stored word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         data <= load_data;
      end else if (drain || clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu_io_unit.sv
// CPU I/O bus unit: one outstanding read/write request at a time, routed to
// one of N_IN input or N_OUT output channels, with stall and optional timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request in flight; accepts req_valid when enabled
// WAIT_IN  | read pending, waiting for the input channel to fill
// WAIT_OUT | write pending, waiting for the output channel to free up
module cpu_io_unit
   import cpu_io_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int N_IN    = 2,
   parameter int N_OUT   = 2,
   parameter int PORT_W  = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    req_valid,
   input  logic                    req_write,
   input  logic [PORT_W-1:0]       req_port,
   input  logic [DATA_W-1:0]       req_data,
   output logic                    req_done,
   output logic                    req_err,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    stall,
   input  logic [N_IN*DATA_W-1:0]  in_data,
   input  logic [N_IN-1:0]         in_valid,
   output logic [N_IN-1:0]         in_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready
);

   localparam int              CNT_W     = io_cnt_width(TIMEOUT);
   localparam int              TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [PORT_W:0] N_IN_LIM  = (PORT_W + 1)'(N_IN);
   localparam logic [PORT_W:0] N_OUT_LIM = (PORT_W + 1)'(N_OUT);

   io_state_e          state;
   io_req_t            req_q;
   logic [CNT_W-1:0]   cnt;

   logic [N_IN-1:0]    in_full;
   logic [N_IN-1:0]    in_drain;
   logic [DATA_W-1:0]  in_hold [N_IN];
   logic [N_OUT-1:0]   out_load;
   logic [N_OUT-1:0]   out_drain;

   logic [PORT_W-1:0]  port_sel;
   logic [DATA_W-1:0]  wr_data;
   logic               sel_full;
   logic [DATA_W-1:0]  sel_hold;
   logic               sel_ov;
   logic               sel_or;
   logic               accept;
   logic               bad_port;
   logic               rd_hit;
   logic               wr_go;
   logic               to_hit;
   logic               req_unused;

   // In IDLE the live request addresses the channel; afterwards the latched copy does.
   assign port_sel = (state == IDLE) ? req_port : req_q.port[PORT_W-1:0];
   assign wr_data  = (state == IDLE) ? req_data : req_q.data[DATA_W-1:0];
   assign accept   = (state == IDLE) && enable && req_valid;
   assign bad_port = req_write ? ({1'b0, req_port} >= N_OUT_LIM)
                               : ({1'b0, req_port} >= N_IN_LIM);
   assign to_hit   = (TIMEOUT > 0) && (cnt == CNT_W'(TO_LAST));
   assign stall    = (state != IDLE);
   assign in_ready = ~in_full;

   // Upper bits of the generic request record are intentionally dropped.
   assign req_unused = ^{req_q.write, req_q.port, req_q.data};

   // Select the addressed channel's status and held data.
   always_comb begin
      sel_full = 1'b0;
      sel_hold = '0;
      sel_ov   = 1'b0;
      sel_or   = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
         if (port_sel == PORT_W'(i)) begin
            sel_full = in_full[i];
            sel_hold = in_hold[i];
         end
      end
      for (int j = 0; j < N_OUT; j++) begin
         if (port_sel == PORT_W'(j)) begin
            sel_ov = out_valid[j];
            sel_or = out_ready[j];
         end
      end
   end

   // Transfer strobes: a read consumes the holding register, a write reloads the output.
   always_comb begin
      rd_hit = enable && sel_full &&
               ((accept && !req_write && !bad_port) || (state == WAIT_IN));
      wr_go  = enable && (!sel_ov || sel_or) &&
               ((accept && req_write && !bad_port) || (state == WAIT_OUT));
      for (int i = 0; i < N_IN; i++) begin
         in_drain[i] = rd_hit && (port_sel == PORT_W'(i));
      end
      for (int j = 0; j < N_OUT; j++) begin
         out_load[j]  = wr_go && (port_sel == PORT_W'(j));
         out_drain[j] = out_valid[j] && out_ready[j];
      end
   end

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      io_slot #(.DATA_W(DATA_W)) u_slot (
         .clock     (clock),
         .reset     (reset),
         .load      (in_valid[i] && !in_full[i]),
         .load_data (in_data[i*DATA_W +: DATA_W]),
         .drain     (in_drain[i]),
         .clear     (1'b0),
         .full      (in_full[i]),
         .data      (in_hold[i])
      );
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      io_slot #(.DATA_W(DATA_W)) u_slot (
         .clock     (clock),
         .reset     (reset),
         .load      (out_load[j]),
         .load_data (wr_data),
         .drain     (out_drain[j]),
         .clear     (1'b0),
         .full      (out_valid[j]),
         .data      (out_data[j*DATA_W +: DATA_W])
      );
   end

   // Request FSM with registered completion outputs; req_done always self-clears.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         req_q    <= '0;
         cnt      <= '0;
         req_done <= 1'b0;
         req_err  <= 1'b0;
         rd_data  <= '0;
      end else begin
         req_done <= 1'b0;
         req_err  <= 1'b0;
         if (enable) begin
            case (state)
               IDLE: begin
                  if (req_valid) begin
                     req_q.write <= req_write;
                     req_q.port  <= REQ_PORT_MAX_W'(req_port);
                     req_q.data  <= REQ_DATA_MAX_W'(req_data);
                     cnt         <= '0;
                     if (bad_port) begin
                        req_done <= 1'b1;
                        req_err  <= 1'b1;
                     end else if (!req_write) begin
                        if (rd_hit) begin
                           req_done <= 1'b1;
                           rd_data  <= sel_hold;
                        end else begin
                           state <= WAIT_IN;
                        end
                     end else if (wr_go) begin
                        req_done <= 1'b1;
                     end else begin
                        state <= WAIT_OUT;
                     end
                  end
               end
               WAIT_IN: begin
                  if (rd_hit) begin
                     req_done <= 1'b1;
                     rd_data  <= sel_hold;
                     state    <= IDLE;
                  end else if (to_hit) begin
                     req_done <= 1'b1;
                     req_err  <= 1'b1;
                     rd_data  <= '0;
                     state    <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               WAIT_OUT: begin
                  if (wr_go) begin
                     req_done <= 1'b1;
                     state    <= IDLE;
                  end else if (to_hit) begin
                     req_done <= 1'b1;
                     req_err  <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/cpu_io_unit.md
Name: cpu_io_unit

Overview:
- Parametrised CPU input/output bus unit that replaces the CPU's single fixed 8-bit input/output path.
- Serves N_IN input channels and N_OUT output channels of DATA_W bits each, over a valid/ready handshake.
- The CPU issues one read or write request at a time. The unit stalls the CPU until the selected channel can complete the transfer, or until the request times out.
- Output channels hold their last value; they never revert to zero.

Parameters:
- DATA_W, 8: channel and bus data width.
- N_IN, 2: number of input channels, minimum 1.
- N_OUT, 2: number of output channels, minimum 1.
- PORT_W, 3: width of the port select field. Must satisfy 2**PORT_W >= max(N_IN, N_OUT).
- TIMEOUT, 255: maximum wait cycles per request. 0 means wait forever.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  request FSM and timeout counter advance only when 1. Channel-side handshakes always run.
- req_valid  in  1  CPU request strobe. Sampled only in IDLE.
- req_write  in  1  1 = write to an output channel, 0 = read from an input channel.
- req_port  in  PORT_W  channel index.
- req_data  in  DATA_W  write data.
- req_done  out  1  one-cycle completion pulse.
- req_err  out  1  valid with req_done. Set for a bad port or a timeout.
- rd_data  out  DATA_W  read result. Holds until the next completion.
- stall  out  1  high while a request is in flight.
- in_data  in  N_IN*DATA_W  packed input channel data. Channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  N_IN  input channel valid.
- in_ready  out  N_IN  input channel ready.
- out_data  out  N_OUT*DATA_W  packed output channel data.
- out_valid  out  N_OUT  output channel valid.
- out_ready  in  N_OUT  output channel ready.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, all holding registers empty, FSM in IDLE, timeout counter 0.
- Input holding register, one per channel, single entry:
  - in_ready[i] = !full[i]. No same-cycle bypass.
  - in_valid[i] && in_ready[i] captures the data and sets full[i].
  - full[i] clears only when the CPU consumes the entry.
- Output register, one per channel, single entry:
  - out_valid[j] clears on out_valid[j] && out_ready[j], unless it is reloaded in the same cycle.
  - out_data[j] is never cleared except by reset.
- FSM states: IDLE, WAIT_IN, WAIT_OUT.
- IDLE with enable && req_valid: latch req_write, req_port and req_data, then branch:
  - Port index >= N_IN (read) or >= N_OUT (write): next cycle req_done=1, req_err=1, rd_data unchanged, no side effects. Stay in IDLE.
  - Read with full[p]: next cycle rd_data = hold[p], full[p] cleared, req_done=1, req_err=0.
  - Read with !full[p]: go to WAIT_IN.
  - Write with !out_valid[p] or out_ready[p] in this cycle: load out_data[p] and set out_valid[p]. req_done=1 next cycle.
  - Write otherwise: go to WAIT_OUT.
- WAIT_IN: complete as a read hit once full[p] is 1 at a clock edge. Data captured at edge k is consumed at edge k+1, and req_done pulses after that edge.
- WAIT_OUT: complete once out_valid[p] is 0 or out_ready[p] is 1. A drain and a reload in the same cycle leave out_valid[p] at 1 with the new data.
- Timeout: the counter resets on entry to a WAIT state and increments each enabled wait cycle. When it reaches TIMEOUT (TIMEOUT > 0):
  - req_done=1 and req_err=1.
  - rd_data = 0 for reads.
  - Return to IDLE. The channel is untouched, so a late input stays in its holding register.
- stall = (state != IDLE). While stall is high, req_valid is ignored.
- enable=0 freezes the FSM and the counter. A pending req_done pulse still completes.
- Fast-path latency is 1 cycle, from request accepted at edge 0 to req_done high after edge 1. Back-to-back requests are accepted in the cycle req_done is high.

Decomposition:
- Package cpu_io_pkg holds:
  - the io_state_e enum (IDLE, WAIT_IN, WAIT_OUT);
  - the request record typedef (write, port, data);
  - a helper function that computes the timeout counter width.
- One sub-module, io_slot: a single-entry valid/ready register with load, drain and clear ports. Instantiate it N_IN times for inputs and N_OUT times for outputs.

Test Plan:
- Reset with DATA_W=8, N_IN=2, N_OUT=2 -> all outputs 0, in_ready=2'b11. Drive in_valid[0] with 0xA5, then issue read port 0 -> req_done after 1 cycle, rd_data=0xA5, in_ready[0] back to 1.
- Read port 1 while its channel is empty, then present 0x3C after 5 cycles -> stall high throughout, req_done with rd_data=0x3C, req_err=0.
- Write 0x11 to port 0 with out_ready=0, then write 0x22 -> second write stalls. Raise out_ready for 1 cycle -> out_data=0x22, out_valid stays 1, req_done.
- Read port 1 with TIMEOUT=4 and no input -> req_done and req_err after 4 wait cycles, rd_data=0x00. A later input is still captured.
- Read port 5 with N_IN=2 -> req_done=1, req_err=1 next cycle, no channel change.
- Assert reset in WAIT_OUT with out_valid=1 -> immediate IDLE, all outputs and registers 0, stall=0.
